molecule_sprite_gen: RTL
========================

# molecule_sprite_gen

Parametrised molecule object for the osmosis display: one instance holds a molecule's position, moves it once per video frame with diagonal bouncing off the screen edges, and reflects it off or passes it through the vertical membrane band according to membrane colour and the molecule's own colour. It supports freeze with single-frame stepping and counts membrane crossings. It drives a registered pixel-hit flag for the colour mux in the top-level renderer.

## Interface
- MOL_SIZE, 16: square side in pixels.
- START_X, 100: reset x (top-left corner).
- START_Y, 100: reset y.
- SPEED, 2: pixels moved per axis per move; 1..15.
- IS_RED, 0: 1 = red molecule, 0 = blue.
- SCREEN_W, 640: visible width.
- SCREEN_H, 480: visible height.
- MEM_X, 316: membrane band left x.
- MEM_W, 8: membrane band width.

- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-low reset.
- frame  in  1  one-cycle strobe per video frame.
- h_cnt  in  10  current pixel x.
- v_cnt  in  10  current pixel y.
- magenta_membrane, red_membrane, blue_membrane, no_membrane  in  1 each  membrane type select.
- membrane_on  in  1  membrane present.
- freeze  in  1  hold motion.
- btnD  in  1  step button (already debounced).
- is_red  out  1  constant IS_RED.
- is_molecule  out  1  registered pixel hit.
- pos_x  out  10  current x.
- pos_y  out  10  current y.
- side  out  1  0 = left of membrane centre, 1 = right.
- cross_cnt  out  8  membrane crossings, wraps.

## Operation
- Reset (reset=0, async): pos = (START_X, START_Y), dir_x = dir_y = +, side = ((START_X + MOL_SIZE/2) >= (MEM_X + MEM_W/2)), cross_cnt = 0, is_molecule = 0, step_pending = 0, btnD_q = 0.
- A move occurs on a clk edge with frame=1 when state = RUN, or when state = STEP_ARMED.
- Control FSM:
  - RUN (freeze=0): a move occurs on every frame.
  - HOLD (freeze=1): no moves. A btnD rising edge (btnD=1, btnD_q=0) goes to STEP_ARMED.
  - STEP_ARMED: the next frame performs exactly one move, then goes to HOLD.
  - freeze=0 in any state goes to RUN and clears the pending step.
- Move arithmetic is done in 11-bit signed; max_x = SCREEN_W-MOL_SIZE, max_y = SCREEN_H-MOL_SIZE. Per axis:
  - nx = pos ± SPEED.
  - If nx < 0: pos = 0 and the direction flips.
  - If nx > max: pos = max and the direction flips.
- Membrane permeability is resolved in priority order:
  - membrane_on=0 or no_membrane: pass all.
  - magenta: block all.
  - red: pass if IS_RED.
  - blue: pass if !IS_RED.
  - no select asserted: block.
- Blocking: if impermeable and nx overlaps the band (nx+MOL_SIZE > MEM_X and nx < MEM_X+MEM_W), pos_x is unchanged and dir_x flips. The y axis still moves normally.
- Side and crossing count: after each move, new side = ((pos_x + MOL_SIZE/2) >= MEM_X + MEM_W/2). If it differs from side, side updates and cross_cnt increments (255→0).
- Pixel hit: is_molecule <= (pos_x <= h_cnt < pos_x+MOL_SIZE) & (pos_y <= v_cnt < pos_y+MOL_SIZE). The comparison uses 11-bit sums.

## Timing
- Position, dir and FSM state update on the clk edge where frame=1. New pos_x/pos_y are visible the following cycle.
- side and cross_cnt update one cycle after the position change.
- is_molecule has 1-cycle latency relative to h_cnt/v_cnt. The renderer delays its colour select by one cycle to match.
- btnD edge and frame in the same cycle while in HOLD: the edge arms STEP_ARMED only. The move happens on the next frame, not the current one.
- A frame while in STEP_ARMED with freeze dropping in the same cycle: the design goes to RUN and this frame performs its move, which is counted once.
- Asserting reset mid-frame immediately returns all outputs to their reset values. Motion resumes on the first frame after release.

## Test plan
- Free run: START_X=100, START_Y=100, SPEED=2, freeze=0, 5 frames → pos = (110,110), cross_cnt = 0.
- Right wall: START_X=620, MOL_SIZE=16, W=640, dir +; pos_x must step 622, 624, 624 (clamped and flipped), 622.
- Blocked membrane: IS_RED=0, magenta, pos_x=300 moving right → pos_x stays 300 and dir_x flips; next frame → 298.
- Pass membrane: red membrane, IS_RED=1, START_X=300, 10 frames → pos_x=320, side goes 0→1, cross_cnt=1.
- Freeze/step: freeze=1, 3 frames → pos unchanged. Then a btnD pulse followed by 3 frames → exactly one move of +2.
- Reset mid-run: assert reset (low) after 7 frames → pos = (START_X, START_Y), cross_cnt=0 and is_molecule=0 with no clk edge needed.

Source files
------------

// File: rtl/molecule_sprite_gen.sv
// molecule_sprite_gen: one bouncing molecule sprite with membrane reflection, freeze/step control and crossing count.
// Position moves once per frame; is_molecule is the registered pixel hit for the renderer colour mux.
module molecule_sprite_gen #(
    parameter int MOL_SIZE = 16,
    parameter int START_X  = 100,
    parameter int START_Y  = 100,
    parameter int SPEED    = 2,
    parameter int IS_RED   = 0,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int MEM_X    = 316,
    parameter int MEM_W    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame,
    input  logic [9:0] h_cnt,
    input  logic [9:0] v_cnt,
    input  logic       magenta_membrane,
    input  logic       red_membrane,
    input  logic       blue_membrane,
    input  logic       no_membrane,
    input  logic       membrane_on,
    input  logic       freeze,
    input  logic       btnD,
    output logic       is_red,
    output logic       is_molecule,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic       side,
    output logic [7:0] cross_cnt
);
    localparam logic signed [10:0] SPD    = 11'(SPEED);
    localparam logic signed [10:0] MS     = 11'(MOL_SIZE);
    localparam logic signed [10:0] BAND_L = 11'(MEM_X);
    localparam logic signed [10:0] BAND_R = 11'(MEM_X + MEM_W);
    localparam logic signed [10:0] MAX_X  = 11'(SCREEN_W - MOL_SIZE);
    localparam logic signed [10:0] MAX_Y  = 11'(SCREEN_H - MOL_SIZE);
    localparam logic [10:0] HALF   = 11'(MOL_SIZE / 2);
    localparam logic [10:0] CENTRE = 11'(MEM_X + MEM_W / 2);
    localparam logic [10:0] SIZE_U = 11'(MOL_SIZE);
    localparam logic        RED_B  = (IS_RED != 0);
    localparam logic        SIDE0  = (START_X + MOL_SIZE / 2) >= (MEM_X + MEM_W / 2);

    typedef enum logic [1:0] {RUN, HOLD, STEP_ARMED} state_t;

    state_t state, state_nx;
    logic btnD_q, dir_x, dir_y, dx_nx, dy_nx;
    logic move, pass, blocked, side_now, hit;
    logic signed [10:0] nx, ny;
    logic [9:0] x_nx, y_nx;

    assign is_red = RED_B;

    always_comb begin
        state_nx = !freeze ? RUN
                 : state == RUN ? HOLD
                 : (state == HOLD && btnD && !btnD_q) ? STEP_ARMED
                 : (state == STEP_ARMED && frame) ? HOLD
                 : state;
        move = frame && (state == RUN || state == STEP_ARMED);
        pass = (!membrane_on || no_membrane) ? 1'b1
             : magenta_membrane ? 1'b0
             : red_membrane ? RED_B
             : blue_membrane ? !RED_B
             : 1'b0;
        nx = $signed({1'b0, pos_x}) + (dir_x ? SPD : -SPD);
        ny = $signed({1'b0, pos_y}) + (dir_y ? SPD : -SPD);
        // an impermeable band acts as a wall: hold x and bounce
        blocked = !pass && (nx + MS > BAND_L) && (nx < BAND_R);
        x_nx = blocked ? pos_x : nx < 11'sd0 ? '0 : nx > MAX_X ? MAX_X[9:0] : nx[9:0];
        dx_nx = (blocked || nx < 11'sd0 || nx > MAX_X) ? !dir_x : dir_x;
        y_nx = ny < 11'sd0 ? '0 : ny > MAX_Y ? MAX_Y[9:0] : ny[9:0];
        dy_nx = (ny < 11'sd0 || ny > MAX_Y) ? !dir_y : dir_y;
        side_now = ({1'b0, pos_x} + HALF) >= CENTRE;
        hit = ({1'b0, h_cnt} >= {1'b0, pos_x}) && ({1'b0, h_cnt} < {1'b0, pos_x} + SIZE_U)
           && ({1'b0, v_cnt} >= {1'b0, pos_y}) && ({1'b0, v_cnt} < {1'b0, pos_y} + SIZE_U);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            btnD_q      <= 1'b0;
            pos_x       <= 10'(START_X);
            pos_y       <= 10'(START_Y);
            dir_x       <= 1'b1;
            dir_y       <= 1'b1;
            side        <= SIDE0;
            cross_cnt   <= '0;
            is_molecule <= 1'b0;
        end else begin
            state       <= state_nx;
            btnD_q      <= btnD;
            is_molecule <= hit;
            if (move) begin
                pos_x <= x_nx;
                pos_y <= y_nx;
                dir_x <= dx_nx;
                dir_y <= dy_nx;
            end
            // side tracks the committed position, so it lags a move by one cycle
            if (side_now != side) begin
                side      <= side_now;
                cross_cnt <= cross_cnt + 8'd1;
            end
        end
    end
endmodule
